// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate generator: format select codes,
// skid-buffer occupancy states and the XLEN legality check.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_ILL   = 3'b111
  } immsrc_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream (instruction in) and downstream (immediate out) handshake bundle.
// The master side is whoever drives instructions and consumes immediates.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [24:0]     instr;
  immsrc_e         immsrc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] immext;
  logic            illegal;

  modport master (
    output in_valid, instr, immsrc, out_ready,
    input  in_ready, out_valid, immext, illegal
  );

  modport slave (
    input  in_valid, instr, immsrc, out_ready,
    output in_ready, out_valid, immext, illegal
  );
endinterface

// File: rtl/imm_fmt_decode.sv
// Combinational RISC-V immediate decoder: instruction bits [31:7] plus a
// format select in, XLEN-wide extended immediate and an illegal flag out.
module imm_fmt_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr,
  input  immsrc_e         immsrc,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);
  // Indexed with architectural bit numbers so the formats read like the ISA manual.
  logic [31:7] ir;
  assign ir = instr;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    immext  = '0;
    illegal = 1'b0;
    case (immsrc)
      IMM_I:     immext = XLEN'($signed(ir[31:20]));
      IMM_S:     immext = XLEN'($signed({ir[31:25], ir[11:7]}));
      IMM_B:     immext = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      IMM_J:     immext = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      IMM_U:     immext = XLEN'($signed({ir[31:12], 12'b0}));
      IMM_SHAMT: immext = (XLEN == 64) ? XLEN'(ir[25:20]) : XLEN'(ir[24:20]);
      IMM_ZIMM:  immext = XLEN'(ir[19:15]);
      IMM_ILL:   illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes on the input side, then holds
// results in an output register plus one skid register (2-entry FIFO).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);
  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  imm_fmt_decode #(.XLEN(XLEN)) u_dec (
    .instr   (bus.instr),
    .immsrc  (bus.immsrc),
    .immext  (dec_imm),
    .illegal (dec_ill)
  );

  occ_e            state;
  logic            out_valid_q;
  logic            in_ready_q;
  logic [XLEN-1:0] out_imm;
  logic            out_ill;
  logic [XLEN-1:0] skid_imm;
  logic            skid_ill;
  logic            push;
  logic            pop;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: both data registers are reset; they are two flops wide, not a RAM,
      // and a defined immext/illegal after reset is part of the contract.
      state       <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_imm     <= '0;
      out_ill     <= 1'b0;
      skid_imm    <= '0;
      skid_ill    <= 1'b0;
    end else if (flush) begin
      // Same-cycle push/pop are discarded; stale data stays but is never valid.
      state       <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (push) begin
            out_imm     <= dec_imm;
            out_ill     <= dec_ill;
            out_valid_q <= 1'b1;
            state       <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            out_imm <= dec_imm;
            out_ill <= dec_ill;
          end else if (push) begin
            skid_imm   <= dec_imm;
            skid_ill   <= dec_ill;
            in_ready_q <= 1'b0;
            state      <= OCC_FULL;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state       <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            out_imm    <= skid_imm;
            out_ill    <= skid_ill;
            in_ready_q <= 1'b1;
            state      <= OCC_ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= OCC_EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.immext    = out_imm;
  assign bus.illegal   = out_ill;
endmodule
